// File: rtl/ccu_operation_sequencer.sv
// Central operation FSM of the CCU: launches datapath iterations, counts beats/iterations/cycles.
// Optional iteration watchdog enabled by defining CCU_WATCHDOG_EN.
module ccu_operation_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int WDT_LIMIT = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_loaded,
    input  logic                 grid_loaded,
    input  logic                 scle_loaded,
    input  logic                 wght_loaded,
    input  logic                 operation_start,
    input  logic                 interrupt_abort,
    input  logic                 interrupt_soft,
    input  logic [CNT_WIDTH-1:0] pckt_size,
    output logic                 dp_start,
    input  logic                 rslt_beat,
    input  logic                 rslt_last,
    output logic                 rw_pl2ps_reg_en,
    output logic                 rslt_loaded_wr,
    output logic                 operation_done_wr,
    output logic                 wo_reg_en,
    output logic                 wo_reg_rst,
    output logic                 status_idle,
    output logic                 status_busy,
    output logic                 status_error,
    output logic                 status_locked,
    output logic                 status_valid,
    output logic [CNT_WIDTH-1:0] progress_rslt,
    output logic [CNT_WIDTH-1:0] progress_iter,
    output logic [CNT_WIDTH-1:0] iteration_timer,
    output logic [CNT_WIDTH-1:0] iteration_latency,
    output logic [CNT_WIDTH-1:0] operation_timer,
    output logic [CNT_WIDTH-1:0] operation_latency
);

    typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT, DONE, ERR} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] WDT_LAST = CNT_WIDTH'(WDT_LIMIT - 1);
`ifdef CCU_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t               state, state_nxt;
    logic                 wo_en_q, pl2ps_q;
    logic                 all_loaded, wdt_trip, beat_ok, iter_done;
    logic [CNT_WIDTH-1:0] iter_nxt, op_nxt;

    assign all_loaded = data_loaded & grid_loaded & scle_loaded & wght_loaded;
    // Trip on the edge where iteration_timer would reach the limit, so ERR follows immediately.
    assign wdt_trip   = WDT_ON && (state == WAIT) && (iteration_timer >= WDT_LAST);
    // Abort and watchdog take priority: a beat in that cycle is discarded.
    assign beat_ok    = (state == WAIT) && rslt_beat && !interrupt_abort && !wdt_trip;
    assign iter_done  = beat_ok && rslt_last;
    assign iter_nxt   = sat_inc(progress_iter);
    assign op_nxt     = sat_inc(operation_timer);

    always_comb begin
        state_nxt         = state;
        dp_start          = 1'b0;
        wo_reg_rst        = 1'b0;
        status_idle       = 1'b0;
        status_busy       = 1'b0;
        status_error      = 1'b0;
        status_valid      = 1'b0;
        status_locked     = 1'b0;
        wo_reg_en         = wo_en_q;
        rw_pl2ps_reg_en   = pl2ps_q;
        rslt_loaded_wr    = pl2ps_q;
        operation_done_wr = pl2ps_q;
        case (state)
            IDLE: begin
                status_idle = 1'b1;
                if (operation_start)
                    state_nxt = (all_loaded && pckt_size != '0) ? CLR : ERR;
            end
            CLR: begin
                status_busy = 1'b1;
                wo_reg_rst  = 1'b1;
                state_nxt   = LAUNCH;
            end
            LAUNCH: begin
                status_busy = 1'b1;
                dp_start    = 1'b1;
                state_nxt   = interrupt_abort ? ERR : WAIT;
            end
            WAIT: begin
                status_busy = 1'b1;
                if (interrupt_abort || wdt_trip)
                    state_nxt = ERR;
                else if (iter_done)
                    state_nxt = (iter_nxt == pckt_size || interrupt_soft) ? DONE : LAUNCH;
            end
            DONE: begin
                status_valid  = 1'b1;
                status_locked = operation_start;
                if (!operation_start)
                    state_nxt = IDLE;
            end
            ERR: begin
                status_error  = 1'b1;
                status_locked = operation_start;
                if (!operation_start && !interrupt_abort)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            wo_en_q           <= 1'b0;
            pl2ps_q           <= 1'b0;
            progress_rslt     <= '0;
            progress_iter     <= '0;
            iteration_timer   <= '0;
            iteration_latency <= '0;
            operation_timer   <= '0;
            operation_latency <= '0;
        end else begin
            state   <= state_nxt;
            wo_en_q <= iter_done;
            pl2ps_q <= iter_done && (state_nxt == DONE);
            case (state)
                CLR: begin
                    progress_rslt     <= '0;
                    progress_iter     <= '0;
                    iteration_timer   <= '0;
                    iteration_latency <= '0;
                    operation_timer   <= '0;
                    operation_latency <= '0;
                end
                LAUNCH: begin
                    iteration_timer <= '0;
                    operation_timer <= op_nxt;
                end
                WAIT: begin
                    iteration_timer <= sat_inc(iteration_timer);
                    operation_timer <= op_nxt;
                    if (beat_ok)
                        progress_rslt <= sat_inc(progress_rslt);
                    if (iter_done) begin
                        progress_iter     <= iter_nxt;
                        iteration_latency <= sat_inc(iteration_timer);
                    end
                    // Latched with the incremented timer so it matches operation_timer in DONE.
                    if (iter_done && state_nxt == DONE)
                        operation_latency <= op_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_operation_sequencer.sv
// Scoreboard bench for ccu_operation_sequencer: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_ccu_operation_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_loaded = 1'b1, grid_loaded = 1'b1, scle_loaded = 1'b1, wght_loaded = 1'b1;
    logic         operation_start = 1'b0, interrupt_abort = 1'b0, interrupt_soft = 1'b0;
    logic [W-1:0] pckt_size = '0;
    logic         rslt_beat = 1'b0, rslt_last = 1'b0;
    logic         dp_start, rw_pl2ps_reg_en, rslt_loaded_wr, operation_done_wr;
    logic         wo_reg_en, wo_reg_rst;
    logic         status_idle, status_busy, status_error, status_locked, status_valid;
    logic [W-1:0] progress_rslt, progress_iter, iteration_timer, iteration_latency;
    logic [W-1:0] operation_timer, operation_latency;

    ccu_operation_sequencer #(.CNT_WIDTH(W), .WDT_LIMIT(50)) dut (
        .clk(clk), .rst(rst),
        .data_loaded(data_loaded), .grid_loaded(grid_loaded),
        .scle_loaded(scle_loaded), .wght_loaded(wght_loaded),
        .operation_start(operation_start), .interrupt_abort(interrupt_abort),
        .interrupt_soft(interrupt_soft), .pckt_size(pckt_size),
        .dp_start(dp_start), .rslt_beat(rslt_beat), .rslt_last(rslt_last),
        .rw_pl2ps_reg_en(rw_pl2ps_reg_en), .rslt_loaded_wr(rslt_loaded_wr),
        .operation_done_wr(operation_done_wr), .wo_reg_en(wo_reg_en), .wo_reg_rst(wo_reg_rst),
        .status_idle(status_idle), .status_busy(status_busy), .status_error(status_error),
        .status_locked(status_locked), .status_valid(status_valid),
        .progress_rslt(progress_rslt), .progress_iter(progress_iter),
        .iteration_timer(iteration_timer), .iteration_latency(iteration_latency),
        .operation_timer(operation_timer), .operation_latency(operation_latency)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 dp_start, 1 wo_reg_en, 2 pl2ps write, 3 entry into error.
    typedef struct {
        int           kind;
        logic [W-1:0] a, b, c, d;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    logic err_prev = 1'b0;

    task automatic push(input int kind, input logic [W-1:0] a, b, c, d);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [W-1:0] a, b, c, d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d (%0d %0d %0d %0d) expected none", kind, a, b, c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b || e.c !== c || e.d !== d) begin
                n_err++;
                $display("FAIL event: got kind %0d (%0d %0d %0d %0d) expected kind %0d (%0d %0d %0d %0d)",
                         kind, a, b, c, d, e.kind, e.a, e.b, e.c, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wo_reg_en)
                observe(1, progress_iter, progress_rslt, iteration_latency, '0);
            if (rw_pl2ps_reg_en)
                observe(2, {30'd0, rslt_loaded_wr, operation_done_wr}, operation_latency,
                        progress_rslt, progress_iter);
            if (dp_start)
                observe(0, '0, '0, '0, '0);
            if (status_error && !err_prev)
                observe(3, progress_iter, progress_rslt, '0, '0);
        end
        err_prev = status_error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        operation_start = 1'b0; interrupt_abort = 1'b0; interrupt_soft = 1'b0;
        rslt_beat = 1'b0; rslt_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_dp();
        int cnt = 0;
        while (!dp_start && cnt < 50) begin
            tick();
            cnt++;
        end
        if (!dp_start) begin
            n_vec++;
            n_err++;
            $display("FAIL dp_start_timeout: got no pulse within 50 cycles expected a pulse");
        end
    endtask

    // Called in the dp_start cycle; 4 beats ending with last at cycle last_at after dp_start.
    task automatic run_iter(input int last_at, input int abort_at, input int soft_at);
        for (int k = 1; k <= last_at + 1; k++) begin
            tick();
            rslt_beat = (k >= last_at - 3) && (k <= last_at);
            rslt_last = (k == last_at);
            if (k == abort_at) interrupt_abort = 1'b1;
            if (k == soft_at)  interrupt_soft  = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_idle", status_idle, 1);
        check("rst_busy", status_busy, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_wo_en", wo_reg_en, 0);
        check("rst_progress_rslt", progress_rslt, 0);

        // Full operation: 3 iterations, 4 beats each, last beat 10 cycles after dp_start
        pckt_size = 3;
        push(0, 0, 0, 0, 0); push(1, 1, 4, 10, 0);
        push(0, 0, 0, 0, 0); push(1, 2, 8, 10, 0);
        push(0, 0, 0, 0, 0); push(1, 3, 12, 10, 0);
        push(2, 3, 33, 12, 3);
        operation_start = 1'b1;
        tick();
        check("t1_clr_wo_reg_rst", wo_reg_rst, 1);
        for (int i = 0; i < 3; i++) begin
            wait_dp();
            run_iter(10, 0, 0);
        end
        check("t1_done_valid", status_valid, 1);
        check("t1_done_locked", status_locked, 1);
        check("t1_op_latency", operation_latency, 33);
        tick();
        check("t1_pl2ps_once", rw_pl2ps_reg_en, 0);
        operation_start = 1'b0;
        tick();
        check("t1_back_idle", status_idle, 1);
        check("t1_unlocked", status_locked, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // Missing loaded flag -> error without launching
        do_reset();
        grid_loaded = 1'b0;
        pckt_size = 3;
        push(3, 0, 0, 0, 0);
        operation_start = 1'b1;
        tick(); tick();
        check("t2_error", status_error, 1);
        check("t2_locked", status_locked, 1);
        check("t2_no_dp", dp_start, 0);
        operation_start = 1'b0;
        tick();
        check("t2_idle", status_idle, 1);
        check("t2_queue_empty", exp_q.size(), 0);
        grid_loaded = 1'b1;

        // Soft stop during iteration 2 of 5
        do_reset();
        pckt_size = 5;
        push(0, 0, 0, 0, 0); push(1, 1, 4, 10, 0);
        push(0, 0, 0, 0, 0); push(1, 2, 8, 10, 0);
        push(2, 3, 22, 8, 2);
        operation_start = 1'b1;
        tick();
        wait_dp(); run_iter(10, 0, 0);
        wait_dp(); run_iter(10, 0, 3);
        check("t3_done_valid", status_valid, 1);
        check("t3_progress_iter", progress_iter, 2);
        interrupt_soft = 1'b0;
        operation_start = 1'b0;
        tick(); tick();
        check("t3_idle", status_idle, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // Abort coincident with the last beat of iteration 1
        do_reset();
        pckt_size = 2;
        push(0, 0, 0, 0, 0);
        push(3, 0, 3, 0, 0);
        operation_start = 1'b1;
        tick();
        wait_dp(); run_iter(10, 10, 0);
        check("t4_error", status_error, 1);
        check("t4_progress_iter", progress_iter, 0);
        check("t4_progress_rslt", progress_rslt, 3);
        operation_start = 1'b0;
        tick();
        check("t4_hold_while_abort", status_error, 1);
        interrupt_abort = 1'b0;
        tick();
        check("t4_idle", status_idle, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // Reset pulsed mid-iteration
        do_reset();
        pckt_size = 4;
        push(0, 0, 0, 0, 0);
        operation_start = 1'b1;
        tick();
        wait_dp();
        for (int k = 1; k <= 5; k++) begin
            tick();
            rslt_beat = (k == 3) || (k == 4);
        end
        check("t5_beats_before_rst", progress_rslt, 2);
        rst = 1'b1;
        operation_start = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_idle", status_idle, 1);
        check("t5_busy", status_busy, 0);
        check("t5_dp_start", dp_start, 0);
        check("t5_progress_rslt", progress_rslt, 0);
        check("t5_op_timer", operation_timer, 0);
        check("t5_iter_timer", iteration_timer, 0);
        tick();
        check("t5_queue_empty", exp_q.size(), 0);

        // No last beat: watchdog timeout or indefinite wait
        do_reset();
        pckt_size = 1;
        push(0, 0, 0, 0, 0);
        push(3, 0, 0, 0, 0);
        operation_start = 1'b1;
        tick();
        wait_dp();
`ifdef CCU_WATCHDOG_EN
        begin
            int cnt = 0;
            while (!status_error && cnt < 200) begin
                tick();
                cnt++;
            end
            check("t6_wdt_latency", cnt, 51);
        end
`else
        repeat (80) tick();
        check("t6_still_busy", status_busy, 1);
        check("t6_iter_timer", iteration_timer, 79);
        interrupt_abort = 1'b1;
        tick(); tick();
        check("t6_abort_error", status_error, 1);
`endif
        interrupt_abort = 1'b0;
        operation_start = 1'b0;
        tick(); tick();
        check("t6_idle", status_idle, 1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccu_operation_sequencer.md
Name: ccu_operation_sequencer

Overview:
- Central operation FSM of the CentralControlUnit; sits beside the CCU register file.
- Consumes PS-written control bits (loaded flags, start, interrupts, sizes) and launches datapath iterations.
- Counts result beats, iterations and cycles; writes status, progress and timing back through the register-file write enables.

Parameters:
CNT_WIDTH, 32, width of all progress counters, timers and size inputs
WDT_LIMIT, 1000000, iteration watchdog limit in cycles (only used with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
data_loaded  in  1  register-file readback
grid_loaded  in  1  register-file readback
scle_loaded  in  1  register-file readback
wght_loaded  in  1  register-file readback
operation_start  in  1  PS start bit (level)
interrupt_abort  in  1  PS abort request (level)
interrupt_soft  in  1  PS soft-stop request (level)
pckt_size  in  CNT_WIDTH  iterations per operation
dp_start  out  1  1-cycle pulse launching one datapath iteration
rslt_beat  in  1  result beat accepted downstream (tvalid&tready)
rslt_last  in  1  qualifies rslt_beat as last beat of iteration
rw_pl2ps_reg_en  out  1  write enable for rslt_loaded/operation_done
rslt_loaded_wr  out  1  result-loaded value
operation_done_wr  out  1  done value
wo_reg_en  out  1  write enable for progress/timer registers
wo_reg_rst  out  1  clear of progress/timer registers
status_idle  out  1  status bit
status_busy  out  1  status bit
status_error  out  1  status bit
status_locked  out  1  status bit
status_valid  out  1  status bit
progress_rslt  out  CNT_WIDTH  result beats this operation
progress_iter  out  CNT_WIDTH  completed iterations
iteration_timer  out  CNT_WIDTH  cycles in current iteration
iteration_latency  out  CNT_WIDTH  cycles of last completed iteration
operation_timer  out  CNT_WIDTH  cycles since operation start
operation_latency  out  CNT_WIDTH  total cycles of last finished operation

Behaviour:
- States: IDLE, CLR, LAUNCH, WAIT, DONE, ERR. Reset -> IDLE; all outputs 0 except status_idle=1.
- IDLE: status_idle=1.
  - operation_start=1 with all four loaded flags set and pckt_size!=0 -> CLR.
  - operation_start=1 otherwise -> ERR.
- CLR (1 cycle): wo_reg_rst=1; all counters/timers cleared -> LAUNCH.
- LAUNCH (1 cycle): dp_start=1; iteration_timer cleared -> WAIT.
- Timers: operation_timer increments every cycle in LAUNCH/WAIT. iteration_timer increments every WAIT cycle. Both saturate at all-ones.
- WAIT:
  - Each rslt_beat increments progress_rslt (saturating).
  - A beat with rslt_last completes the iteration: progress_iter+1 and iteration_latency=iteration_timer+1, both registered. wo_reg_en=1 in the following cycle.
  - Next state after completion: DONE if the new progress_iter==pckt_size or interrupt_soft=1, else LAUNCH.
- interrupt_abort=1 in LAUNCH/WAIT -> ERR next cycle. Abort wins over a simultaneous rslt_last: that beat is not counted.
- interrupt_soft=1 never truncates an iteration in progress.
- status_busy=1 in CLR/LAUNCH/WAIT.
- DONE entry cycle: operation_latency=operation_timer; wo_reg_en=1; rw_pl2ps_reg_en=1 with rslt_loaded_wr=1 and operation_done_wr=1.
- DONE: status_valid=1; stays until operation_start=0 -> IDLE.
- ERR: status_error=1; no pl2ps write. Leaves to IDLE only when operation_start=0 and interrupt_abort=0.
- status_locked = (DONE or ERR) and operation_start=1.
- Exactly one of idle/busy/error/valid is 1 at any time.
- rst mid-operation: immediate return to IDLE. dp_start does not pulse. Counters cleared.
- rslt_beat outside WAIT is ignored.

Optional Feature:
- Macro CCU_WATCHDOG_EN.
- Defined: iteration_timer reaching WDT_LIMIT in WAIT forces ERR on the next cycle; counters frozen.
- Undefined: no timeout; WAIT persists indefinitely. WDT_LIMIT unused.

Test Plan:
- All loaded, pckt_size=3, start=1; each iteration gives 4 beats, last beat 10 cycles after dp_start -> 3 dp_start pulses; progress_rslt=12, progress_iter=3, iteration_latency=10; DONE with done/rslt_loaded written once; start=0 -> IDLE.
- grid_loaded=0, start=1 -> ERR, status_error=1, status_locked=1, no dp_start; start=0 -> IDLE.
- pckt_size=5; interrupt_soft asserted during iteration 2 -> iteration 2 completes; DONE with progress_iter=2.
- Abort asserted in the same cycle as rslt_last of iteration 1 -> ERR; progress_iter=0, progress_rslt excludes that beat.
- rst pulsed in WAIT -> IDLE next cycle, all counters 0, status_idle=1.
- With CCU_WATCHDOG_EN and WDT_LIMIT=50, no rslt_last -> ERR 51 cycles after dp_start. Without the macro -> remains in WAIT.
